// File: rtl/uart_tx_serializer.sv
// ============================================================================
// uart_tx_serializer
//
// UART transmit stage fed by the 16x (or 8x) oversample clock from the baud
// rate generator.  One byte is held in the transmit holding register (THR)
// and serialized from the transmit shift register (TSR) onto TXD as:
//   start bit, 5..8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
// BAUDOUT_CLK is only ever sampled in the CLK domain; its rising edges become
// a one-cycle tick enable.
//
// Optional feature macro: UART_TX_BREAK_EN
//   defined   -> BREAK=1 forces TXD low (one cycle after it is sampled) while
//                the frame engine keeps running underneath.
//   undefined -> BREAK is accepted but has no effect.
//
// Ports:
//   CLK          system clock (same clock as the baud rate generator)
//   RST_N        synchronous active-low reset
//   BAUDOUT_CLK  oversample clock from the baud generator, edge-detected here
//   TX_DATA      byte to transmit
//   TX_VALID     TX_DATA valid; accepted when TX_READY is also high
//   TX_READY     THR empty
//   WLS          word length select: 0..3 -> 5..8 data bits
//   STB          0 = 1 stop bit, 1 = 2 stop bits (1.5 when WLS = 0)
//   PEN          parity enable
//   EPS          1 = even parity, 0 = odd parity
//   BREAK        force line break (only with UART_TX_BREAK_EN)
//   TXD          serial output, idles high
//   THRE         THR empty (same as TX_READY)
//   TEMT         THR empty and the shifter idle
// ============================================================================
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              BAUDOUT_CLK,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    input  logic [1:0]        WLS,
    input  logic              STB,
    input  logic              PEN,
    input  logic              EPS,
    input  logic              BREAK,
    output logic              TXD,
    output logic              THRE,
    output logic              TEMT
);

    // Tick counter must reach 2*OVERSAMPLE-1 for the two-stop-bit case.
    localparam int TCW = $clog2(2 * OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic              baud_q;
    logic              tick;
    logic [DATA_W-1:0] thr;
    logic              thr_full;
    logic [DATA_W-1:0] tsr;
    logic [TCW-1:0]    tick_cnt;
    logic [2:0]        bit_cnt;
    logic [1:0]        wls_q;
    logic              stb_q;
    logic              pen_q;
    logic              parity_q;
    logic              txd_q;

    logic [DATA_W-1:0] wls_mask;
    logic              data_parity;
    logic [TCW-1:0]    stop_last;
    logic [TCW-1:0]    bit_last;
    logic              bit_end;
    logic              load_frame;

    assign tick = BAUDOUT_CLK & ~baud_q;

    // Parity covers only the data bits that will actually be sent, so the
    // unused upper THR bits are masked off using the word length in force
    // when the frame is loaded.
    always_comb begin
        wls_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            wls_mask[i] = (i < (5 + int'(WLS)));
        end
        data_parity = ^(thr & wls_mask);
    end

    // Last tick index of the current bit; the stop phase alone may be
    // longer than one bit (1.5 or 2 bit times).
    always_comb begin
        if (!stb_q) begin
            stop_last = TCW'(OVERSAMPLE - 1);
        end else if (wls_q == 2'd0) begin
            stop_last = TCW'((OVERSAMPLE * 3) / 2 - 1);
        end else begin
            stop_last = TCW'(2 * OVERSAMPLE - 1);
        end
        bit_last   = (state == STOP) ? stop_last : TCW'(OVERSAMPLE - 1);
        bit_end    = tick && (tick_cnt == bit_last);
        // A new frame starts from IDLE straight away, or at the end of the
        // stop phase so back-to-back frames have no idle gap.
        load_frame = thr_full && ((state == IDLE) || ((state == STOP) && bit_end));
    end

    // Frame engine: THR handshake, THR->TSR transfer, bit timing and the
    // registered serial output all live here.  The tick that coincides with
    // a frame load is deliberately not counted toward the start bit.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            baud_q   <= 1'b0;
            thr      <= '0;
            thr_full <= 1'b0;
            tsr      <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            wls_q    <= '0;
            stb_q    <= 1'b0;
            pen_q    <= 1'b0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            baud_q <= BAUDOUT_CLK;

            if (TX_VALID && !thr_full) begin
                thr      <= TX_DATA;
                thr_full <= 1'b1;
            end

            if (load_frame) begin
                tsr      <= thr;
                thr_full <= 1'b0;
                wls_q    <= WLS;
                stb_q    <= STB;
                pen_q    <= PEN;
                parity_q <= EPS ? data_parity : ~data_parity;
                tick_cnt <= '0;
                bit_cnt  <= '0;
                state    <= START;
                txd_q    <= 1'b0;
            end else begin
                if (state == IDLE || bit_end) begin
                    tick_cnt <= '0;
                end else if (tick) begin
                    tick_cnt <= tick_cnt + TCW'(1);
                end

                case (state)
                    IDLE: begin
                        txd_q <= 1'b1;
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            txd_q   <= tsr[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            tsr <= tsr >> 1;
                            if (bit_cnt == ({1'b0, wls_q} + 3'd4)) begin
                                if (pen_q) begin
                                    state <= PARITY;
                                    txd_q <= parity_q;
                                end else begin
                                    state <= STOP;
                                    txd_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                txd_q   <= tsr[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state <= STOP;
                            txd_q <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            state <= IDLE;
                            txd_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        txd_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign TX_READY = ~thr_full;
    assign THRE     = ~thr_full;
    assign TEMT     = (state == IDLE) && !thr_full;

`ifdef UART_TX_BREAK_EN
    logic break_q;

    // Break overrides the line one cycle after BREAK is sampled; the frame
    // engine is not paused, so whatever it was sending is lost.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            break_q <= 1'b0;
        end else begin
            break_q <= BREAK;
        end
    end

    assign TXD = txd_q & ~break_q;
`else
    logic unused_break;

    assign unused_break = BREAK;
    assign TXD          = txd_q;
`endif

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit stage that sits directly downstream of the baud_rate generator and consumes its BAUDOUT_CLK (16x oversample clock).
- Holds one byte in a transmit holding register (THR) and serializes it from a transmit shift register (TSR) onto TXD.
- Serial frame: start bit, 5-8 data bits LSB first, optional parity bit, 1/1.5/2 stop bits.
- Fully synchronous to CLK; BAUDOUT_CLK is used as a sampled enable, never as a clock.

Parameters:
OVERSAMPLE, 16, baud ticks per serial bit; legal values 8 or 16.
DATA_W, 8, width of TX_DATA and of the THR/TSR.

Ports:
CLK  input  1  system clock, same clock that drives baud_rate.
RST_N  input  1  synchronous active-low reset, sampled on rising CLK.
BAUDOUT_CLK  input  1  16x baud output from baud_rate; its rising edges are detected in the CLK domain.
TX_DATA  input  DATA_W  byte to transmit.
TX_VALID  input  1  TX_DATA is valid.
TX_READY  output  1  THR is empty; a write is accepted on TX_VALID & TX_READY.
WLS  input  2  word length select: 0=5, 1=6, 2=7, 3=8 bits.
STB  input  1  0 = 1 stop bit; 1 = 2 stop bits (1.5 stop bits when WLS=0).
PEN  input  1  parity enable.
EPS  input  1  1 = even parity, 0 = odd parity.
BREAK  input  1  force break; used only when the break feature is compiled in.
TXD  output  1  serial output; idle level is 1.
THRE  output  1  THR empty; equal to TX_READY.
TEMT  output  1  THR empty and TSR idle.

Behaviour:
- Reset: RST_N=0 at a rising CLK edge clears the state.
  - Post-reset values: TXD=1, TX_READY=1, THRE=1, TEMT=1, state=IDLE.
  - THR is marked empty; the tick counter, bit counter and baud edge register are all 0.
  - Reset mid-frame aborts the frame; TXD is 1 on the cycle after that edge.
- Tick: tick = BAUDOUT_CLK & ~baud_q, where baud_q is BAUDOUT_CLK registered on CLK.
  - Tick asserts for one CLK cycle per BAUDOUT_CLK rising edge.
- THR write: on TX_VALID & TX_READY, TX_DATA is latched into the THR.
  - TX_READY deasserts on the next cycle.
  - TX_VALID while TX_READY=0 is ignored; there is no overwrite.
- State machine: IDLE, START, DATA, PARITY, STOP. Each bit lasts OVERSAMPLE ticks, counted by a tick counter that resets at each bit boundary.
  - IDLE: when the THR is full, the next CLK edge does the following:
    - THR moves to the TSR; WLS/STB/PEN/EPS are captured into frame config registers.
    - THR becomes empty, so TX_READY=1 on that same edge.
    - State goes to START with TXD=0.
    - Config changes mid-frame do not affect the current frame.
  - START: TXD=0 for OVERSAMPLE ticks, then DATA.
  - DATA: TXD = TSR[0]; the TSR shifts right at each bit end. After 5+WLS bits, go to PARITY if PEN=1, else STOP.
  - PARITY: TXD = XOR of the captured data bits when EPS=1; the inverse of that XOR when EPS=0. Only the 5+WLS bits in use are included. Lasts one bit, then STOP.
  - STOP: TXD=1. Duration:
    - STB=0: 1 bit.
    - STB=1 and WLS!=0: 2 bits.
    - STB=1 and WLS=0: 1.5 bits (24 ticks at OVERSAMPLE=16).
  - End of STOP: if the THR is full, go directly to START with the next byte (no idle gap, back-to-back frames); otherwise go to IDLE.
- TEMT=1 only in IDLE with the THR empty.
- A THR write and a THR-to-TSR transfer on the same cycle cannot collide, because a write requires TX_READY=1.
- A tick arriving on the IDLE-to-START transfer cycle is not counted; bit timing starts from the first tick after entry to START.
- BAUDOUT_CLK stuck at a constant level means no ticks: the frame stalls and holds TXD at its current value.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined: while BREAK=1, TXD is forced to 0 the cycle after sampling. The state machine keeps running underneath and frames are lost. When BREAK falls, TXD follows the state machine on the next cycle.
- Undefined: the BREAK port is present but ignored, and no break logic is synthesized.

Test Plan:
- Reset with BAUDOUT_CLK toggling every 2 CLK cycles, then deassert RST_N -> TXD=1, TX_READY=1, TEMT=1; no activity for 200 cycles.
- Write 0xA5 with WLS=3, PEN=0, STB=0 -> TXD: 0 for 16 ticks, then 1,0,1,0,0,1,0,1 at 16 ticks each, then 1 for 16 ticks; TEMT returns to 1; total 160 ticks.
- Write 0x35 with WLS=3, PEN=1, EPS=1 -> parity bit is 0 (four ones). Repeat with EPS=0 -> parity bit is 1. Write 0x1F with WLS=0 -> 5 data bits 1,1,1,1,1.
- Write 0x01 and, while it is in the DATA state, write 0x80; keep TX_VALID high with a third byte -> third byte stalls until TX_READY rises at the START of 0x80; stop bit of 0x01 is followed immediately by the start bit of 0x80 with no idle.
- WLS=0, STB=1 -> stop phase lasts 24 ticks. WLS=2, STB=1 -> stop phase lasts 32 ticks.
- Assert RST_N=0 mid-DATA -> TXD=1 one cycle later, TX_READY=1. With UART_TX_BREAK_EN defined, BREAK=1 during a frame -> TXD=0 until BREAK=0.
